imm_pack: RTL

- Inverse of the ASIP immediate extender: takes an 18-bit extended immediate plus ImmSrc and produces the 11-bit instruction immediate field Instr[10:0].
- Flags values the extender cannot reproduce.
- Sits in the instruction-build path: program loader and branch-offset patcher feed it; the instruction-memory writer consumes it.
- Streaming block: valid/ready in and out, 2-entry output buffer, error statistics.

---
 rtl/asip_imm_pkg.sv | 55 +++++
 rtl/imm_pack_fifo2.sv | 63 ++++++
 rtl/imm_pack.sv | 87 ++++++++
 3 files changed

// File: rtl/asip_imm_pkg.sv
// Shared types and pure encode/re-extend helpers for the ASIP immediate packer.
package asip_imm_pkg;

   localparam int EXTIMM_W = 18;
   localparam int FIELD_W  = 11;
   localparam int BR_SHIFT = 2;

   typedef enum logic [1:0] {
      IMM_DP  = 2'b00,
      IMM_MEM = 2'b01,
      IMM_BR  = 2'b10,
      IMM_RSV = 2'b11
   } imm_src_t;

   typedef enum logic [1:0] {
      ERR_OK     = 2'b00,
      ERR_RANGE  = 2'b01,
      ERR_ALIGN  = 2'b10,
      ERR_BADSRC = 2'b11
   } imm_err_t;

   typedef struct packed {
      logic [FIELD_W-1:0] field;
      imm_err_t           err;
   } pack_res_t;

   // Branch check order gives ALIGN priority over RANGE; the field stays zero on any error.
   function automatic pack_res_t pack_imm(input logic [EXTIMM_W-1:0] imm, input imm_src_t src);
      pack_res_t r;
      r.field = {FIELD_W{1'b0}};
      r.err   = ERR_OK;
      case (src)
         IMM_DP, IMM_MEM: begin
            if (imm[EXTIMM_W-1:4] == 14'd0) r.field = {7'd0, imm[3:0]};
            else                             r.err   = ERR_RANGE;
         end
         IMM_BR: begin
            if (imm[BR_SHIFT-1:0] != {BR_SHIFT{1'b0}})
               r.err = ERR_ALIGN;
            else if (!imm[17] && (imm[16:13] == {4{imm[12]}}))
               r.field = imm[BR_SHIFT+FIELD_W-1:BR_SHIFT];
            else
               r.err = ERR_RANGE;
         end
         default: r.err = ERR_BADSRC;
      endcase
      return r;
   endfunction

   function automatic logic [EXTIMM_W-1:0] extend_imm(input logic [FIELD_W-1:0] f, input imm_src_t src);
      if (src == IMM_BR) return {1'b0, {4{f[10]}}, f, {BR_SHIFT{1'b0}}};
      else               return {14'd0, f[3:0]};
   endfunction

endpackage

// File: rtl/imm_pack_fifo2.sv
// Two-entry registered FIFO (head/tail shift form); full/empty are registered flags.
module imm_pack_fifo2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_head,
   output logic         o_full,
   output logic         o_empty
);

   logic [W-1:0] r_head;
   logic [W-1:0] r_tail;
   logic [1:0]   r_cnt;
   logic         r_full;
   logic         r_empty;
   logic         w_push;
   logic         w_pop;
   logic [1:0]   w_cnt_nxt;

   assign w_pop     = i_pop && !r_empty;
   assign w_push    = i_push && !r_full;
   assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

   // Storage: a pop with a second entry waiting shifts the tail into the head.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_head <= {W{1'b0}};
         r_tail <= {W{1'b0}};
      end else begin
         case (r_cnt)
            2'd0: if (w_push) r_head <= i_data;
            2'd1: begin
               if (w_push && w_pop) r_head <= i_data;
               else if (w_push)     r_tail <= i_data;
            end
            2'd2: if (w_pop) r_head <= r_tail;
            default: r_head <= r_head;
         endcase
      end
   end

   // Occupancy and flags are registered so in_ready never depends on out_ready.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt   <= 2'd0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         r_cnt   <= w_cnt_nxt;
         r_full  <= (w_cnt_nxt == 2'd2);
         r_empty <= (w_cnt_nxt == 2'd0);
      end
   end

   assign o_head  = r_head;
   assign o_full  = r_full;
   assign o_empty = r_empty;

endmodule

// File: rtl/imm_pack.sv
// Streaming inverse of the immediate extender with error statistics.
// Optional IMM_PACK_ROUNDTRIP_CHECK_EN adds a registered rt_mismatch flag.
module imm_pack
   import asip_imm_pkg::*;
#(
   parameter int TAG_W = 4,
   parameter int CNT_W = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [17:0]         in_imm,
   input  logic [1:0]          in_src,
   input  logic [TAG_W-1:0]    in_tag,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [10:0]         out_field,
   output logic [1:0]          out_err,
   output logic [TAG_W-1:0]    out_tag,
   output logic                err_sticky,
   output logic [CNT_W-1:0]    err_cnt,
`ifdef IMM_PACK_ROUNDTRIP_CHECK_EN
   output logic                rt_mismatch,
`endif
   input  logic                clr_err
);

   pack_res_t        w_res;
   logic             w_acc;
   logic             w_full;
   logic             w_empty;
   logic             r_sticky;
   logic [CNT_W-1:0] r_err_cnt;

   assign w_res = pack_imm(in_imm, imm_src_t'(in_src));
   assign w_acc = in_valid && !w_full;

`ifdef IMM_PACK_ROUNDTRIP_CHECK_EN
   localparam int PW = FIELD_W + 3 + TAG_W;
   logic          w_rt;
   logic [PW-1:0] w_din;
   logic [PW-1:0] w_head;
   assign w_rt  = (w_res.err == ERR_OK) &&
                  (extend_imm(w_res.field, imm_src_t'(in_src)) != in_imm);
   assign w_din = {w_rt, w_res, in_tag};
   assign {rt_mismatch, out_field, out_err, out_tag} = w_head;
`else
   localparam int PW = FIELD_W + 2 + TAG_W;
   logic [PW-1:0] w_din;
   logic [PW-1:0] w_head;
   assign w_din = {w_res, in_tag};
   assign {out_field, out_err, out_tag} = w_head;
`endif

   imm_pack_fifo2 #(.W(PW)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_acc),
      .i_data  (w_din),
      .i_pop   (out_ready),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign in_ready  = !w_full;
   assign out_valid = !w_empty;

   // Statistics count at acceptance; a coincident clear takes priority.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sticky  <= 1'b0;
         r_err_cnt <= {CNT_W{1'b0}};
      end else if (clr_err) begin
         r_sticky  <= 1'b0;
         r_err_cnt <= {CNT_W{1'b0}};
      end else if (w_acc && (w_res.err != ERR_OK)) begin
         r_sticky <= 1'b1;
         if (r_err_cnt != {CNT_W{1'b1}}) r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
   end

   assign err_sticky = r_sticky;
   assign err_cnt    = r_err_cnt;

endmodule
